my_cpu16_seq: RTL and testbench
===============================

Name: my_cpu16_seq

Overview:
- Multi-cycle control sequencer for the 16-bit CPU datapath (register file, ALU, decoder, instruction memory).
- Owns the PC and IR and runs a fetch/decode/execute/writeback cycle.
- Fetch uses a request/acknowledge memory handshake.
- Gates register-file writes so each instruction writes exactly once.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 2, PC increment per retired instruction (byte-addressed, 2-byte instructions).
- MEM_TIMEOUT, 15, maximum FETCH wait cycles without MEM_ACK before an error halt (1..255).
- HALT_OP, 16'hFFFF, IR encoding treated as the halt instruction.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- RUN  in  1  level; 1 = keep executing, 0 = stop in IDLE after the current instruction.
- MEM_REQ  out  1  fetch request.
- MEM_ADDR  out  16  fetch address; equals PC.
- MEM_ACK  in  1  fetch data valid; only meaningful while MEM_REQ=1.
- MEM_DATA  in  16  instruction word.
- IS_LEGAL  in  1  decoder result for the current IR (ALU, ADDI or LDIn encoding).
- IR  out  16  instruction register, drives decoder and register-number fields.
- REG_WE  out  1  register-file write enable.
- PC  out  16  program counter.
- STATE  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
- HALTED  out  1  1 while in HALT.
- ERR  out  1  sticky; 1 = halted on fault.
- ERR_CODE  out  2  0 = none, 1 = fetch timeout, 2 = illegal opcode.
- RETIRED  out  16  count of completed WB cycles, wraps at 2^16.

Behaviour:
- Reset (asynchronous, immediate): STATE=IDLE, PC=RESET_PC, IR=0, MEM_REQ=0, REG_WE=0, HALTED=0, ERR=0, ERR_CODE=0, RETIRED=0, wait counter=0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- IDLE: if RUN=1 → FETCH, else stay. MEM_ACK is ignored.
- FETCH: MEM_REQ=1 and MEM_ADDR=PC, held stable for the whole state. The wait counter increments every cycle.
  - MEM_ACK=1 at an edge: IR<=MEM_DATA, counter clears, → DECODE.
  - Counter reaching MEM_TIMEOUT with MEM_ACK=0: → HALT, ERR=1, ERR_CODE=1.
  - MEM_ACK=1 on the timeout edge: the ACK wins.
- DECODE (1 cycle):
  - IR==HALT_OP → HALT, ERR=0.
  - Else IS_LEGAL=0 → HALT, ERR=1, ERR_CODE=2.
  - Else → EXEC.
- EXEC (1 cycle): the ALU operands/result settle; REG_WE=0.
- WB (1 cycle):
  - REG_WE=1 for exactly this cycle.
  - At the exit edge: PC<=PC+PC_INC (mod 2^16; 16'hFFFE wraps to 16'h0000) and RETIRED increments.
  - Next state: RUN=1 → FETCH, RUN=0 → IDLE.
- HALT: terminal until RST; RUN and MEM_ACK are ignored; PC, IR and RETIRED are frozen.
- Throughput: 4 cycles per instruction when MEM_ACK arrives in the first FETCH cycle, plus 1 cycle per extra wait.
- MEM_ACK outside FETCH is ignored and has no effect on IR.
- RUN deasserted mid-instruction: the current instruction still completes its WB, then the sequencer enters IDLE.
- RST mid-WB: REG_WE drops asynchronously and the PC increment is lost.
- Halt instruction: not retired; PC stays at its address.

Optional Feature:
- Macro: CPU16_SEQ_STEP_EN.
- Defined:
  - Adds input STEP (1 bit).
  - A registered rising-edge detect of STEP moves IDLE → FETCH for exactly one instruction.
  - WB always returns to IDLE unless RUN=1.
  - The STEP edge is ignored outside IDLE.
- Undefined: no STEP port; behaviour exactly as above.

Test Plan:
- Reset then RUN=1, memory ACKs the first cycle, instructions 16'h20CF, 16'h21CF, 16'h00A1 (all IS_LEGAL=1) → REG_WE pulses at cycles 4, 8, 12; PC = 2, 4, 6; RETIRED = 3.
- ACK delayed 3 cycles on the second fetch → that instruction takes 7 cycles; MEM_ADDR stays 16'h0002 throughout FETCH.
- No ACK with MEM_TIMEOUT=15 → HALT after 15 FETCH cycles; ERR=1, ERR_CODE=1, REG_WE never asserted.
- IS_LEGAL=0 for fetched word 16'h5000 → HALT from DECODE, ERR_CODE=2, PC unchanged, RETIRED unchanged; then RST → IDLE with all outputs at reset values.
- HALT_OP fetched at PC=16'h0006 → HALTED=1, ERR=0, PC=6; RUN toggling has no effect.
- RUN dropped during EXEC → WB completes, then IDLE; RESET_PC=16'hFFFE → after one instruction PC=16'h0000.

Source files
------------

// File: rtl/my_cpu16_seq_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
// Signals: mem_req/mem_addr from the sequencer, mem_ack/mem_data returned by memory.
// mem_ack qualifies mem_data and is only meaningful while mem_req is high.
interface my_cpu16_seq_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/my_cpu16_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit CPU; owns PC and IR.
// Latency: 4 cycles per instruction with first-cycle mem_ack, +1 per extra fetch wait cycle.
// Backpressure: FETCH holds mem_req/mem_addr until mem_ack; no ack within MEM_TIMEOUT cycles halts with error.
// Ports: clk, rst (async active-high), run, bus (fetch interface, master), is_legal, ir, reg_we,
//        pc, state, halted, err, err_code, retired. Optional CPU16_SEQ_STEP_EN adds input step
//        (rising edge runs one instruction from IDLE).
module my_cpu16_seq #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned PC_INC      = 2,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [15:0] HALT_OP     = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
`ifdef CPU16_SEQ_STEP_EN
  input  logic                  step,
`endif
  my_cpu16_seq_if.master        bus,
  input  logic                  is_legal,
  output logic [15:0]           ir,
  output logic                  reg_we,
  output logic [15:0]           pc,
  output logic [2:0]            state,
  output logic                  halted,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [15:0]           retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // The counter is compared before it increments, so the last allowed wait is MEM_TIMEOUT-1.
  localparam logic [7:0]  TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [15:0] PC_STEP      = 16'(PC_INC);

  state_t     st;
  logic [7:0] wait_cnt;
  logic       mem_req_q;
  logic       go;

`ifdef CPU16_SEQ_STEP_EN
  // Registered edge detect: step_pulse is high for one cycle after step rises.
  logic step_q;
  logic step_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_q     <= step;
      step_pulse <= step & ~step_q;
    end
  end

  assign go = run | step_pulse;
`else
  assign go = run;
`endif

  assign state        = st;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= 16'h0000;
      mem_req_q <= 1'b0;
      reg_we    <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      retired   <= 16'h0000;
      wait_cnt  <= 8'd0;
    end else begin
      case (st)
        S_IDLE: begin
          if (go) begin
            st        <= S_FETCH;
            mem_req_q <= 1'b1;
            wait_cnt  <= 8'd0;
          end
        end
        S_FETCH: begin
          // An ack on the timeout edge still wins.
          if (bus.mem_ack) begin
            ir        <= bus.mem_data;
            wait_cnt  <= 8'd0;
            mem_req_q <= 1'b0;
            st        <= S_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TIMEOUT_LAST) begin
              mem_req_q <= 1'b0;
              halted    <= 1'b1;
              err       <= 1'b1;
              err_code  <= 2'd1;
              st        <= S_HALT;
            end
          end
        end
        S_DECODE: begin
          if (ir == HALT_OP) begin
            halted <= 1'b1;
            st     <= S_HALT;
          end else if (!is_legal) begin
            halted   <= 1'b1;
            err      <= 1'b1;
            err_code <= 2'd2;
            st       <= S_HALT;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Raising reg_we here makes it a single-cycle pulse aligned with WB.
          reg_we <= 1'b1;
          st     <= S_WB;
        end
        S_WB: begin
          reg_we  <= 1'b0;
          pc      <= pc + PC_STEP;
          retired <= retired + 16'd1;
          if (run) begin
            mem_req_q <= 1'b1;
            wait_cnt  <= 8'd0;
            st        <= S_FETCH;
          end else begin
            st <= S_IDLE;
          end
        end
        S_HALT: begin
          st <= S_HALT;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_cpu16_seq.sv
module tb_my_cpu16_seq;
  logic clk = 1'b0;
  logic rst;
  logic run;
  logic run2;
  logic step;
  logic force_ack;

  logic [15:0] ir, pc, retired;
  logic [2:0]  state;
  logic        reg_we, halted, err;
  logic [1:0]  err_code;
  logic        is_legal;

  logic [15:0] ir2, pc2, retired2;
  logic [2:0]  state2;
  logic        reg_we2, halted2, err2;
  logic [1:0]  err_code2;

  logic [15:0] mem [0:15];
  int          del_tab [0:15];
  int          fcnt;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  my_cpu16_seq_if mem_if ();
  my_cpu16_seq_if mem_if2 ();

  // Decoder stand-in: only the word 16'h5000 is illegal.
  assign is_legal = (ir != 16'h5000);

  my_cpu16_seq dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef CPU16_SEQ_STEP_EN
    .step(step),
`endif
    .bus(mem_if), .is_legal(is_legal), .ir(ir), .reg_we(reg_we), .pc(pc),
    .state(state), .halted(halted), .err(err), .err_code(err_code), .retired(retired)
  );

  my_cpu16_seq #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst), .run(run2),
`ifdef CPU16_SEQ_STEP_EN
    .step(step),
`endif
    .bus(mem_if2), .is_legal(1'b1), .ir(ir2), .reg_we(reg_we2), .pc(pc2),
    .state(state2), .halted(halted2), .err(err2), .err_code(err_code2), .retired(retired2)
  );

  // Memory model: acks after del_tab[word] wait cycles of a request.
  always @(negedge clk) begin
    if (mem_if.mem_req) begin
      if (fcnt >= del_tab[mem_if.mem_addr[4:1]]) begin
        mem_if.mem_ack  = 1'b1;
        mem_if.mem_data = mem[mem_if.mem_addr[4:1]];
      end else begin
        mem_if.mem_ack  = 1'b0;
        mem_if.mem_data = 16'h0000;
      end
      fcnt = fcnt + 1;
    end else begin
      fcnt            = 0;
      mem_if.mem_ack  = force_ack;
      mem_if.mem_data = 16'hDEAD;
    end
  end

  always @(negedge clk) begin
    mem_if2.mem_ack  = mem_if2.mem_req;
    mem_if2.mem_data = 16'h20CF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; run2 = 1'b0; step = 1'b0; force_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'hFFFF;
      del_tab[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (pc !== 16'h0000 || ir !== 16'h0000) begin failures++; $display("FAIL reset_pc_ir got pc=%h ir=%h exp 0000/0000", pc, ir); end
    checks++; if ({mem_if.mem_req, reg_we, halted, err, err_code} !== 6'b0) begin failures++; $display("FAIL reset_flags got req=%b we=%b h=%b e=%b ec=%0d exp all 0", mem_if.mem_req, reg_we, halted, err, err_code); end
    checks++; if (retired !== 16'h0000) begin failures++; $display("FAIL reset_retired got=%h exp=0000", retired); end
    checks++; if (pc2 !== 16'hFFFE) begin failures++; $display("FAIL reset_pc_param got=%h exp=FFFE", pc2); end
    // Ack while idle must not load IR or start a fetch.
    force_ack = 1'b1;
    tick(); tick(); tick();
    checks++; if (state !== 3'd0 || ir !== 16'h0000 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL idle_ack got st=%0d ir=%h req=%b exp 0/0000/0", state, ir, mem_if.mem_req); end
    force_ack = 1'b0;
  endtask

  task automatic test_three_instr();
    logic exp_we;
    do_reset();
    mem[0] = 16'h20CF; mem[1] = 16'h21CF; mem[2] = 16'h00A1; mem[3] = 16'hFFFF;
    run = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp_we = (c == 4 || c == 8 || c == 12);
      checks++; if (reg_we !== exp_we) begin failures++; $display("FAIL we_cycle%0d got=%b exp=%b", c, reg_we, exp_we); end
      if (c == 2) begin
        checks++; if (ir !== 16'h20CF) begin failures++; $display("FAIL ir_first got=%h exp=20CF", ir); end
      end
      if (c == 5) begin
        checks++; if (pc !== 16'h0002) begin failures++; $display("FAIL pc_after1 got=%h exp=0002", pc); end
      end
      if (c == 9) begin
        checks++; if (pc !== 16'h0004) begin failures++; $display("FAIL pc_after2 got=%h exp=0004", pc); end
      end
      if (c == 13) begin
        checks++; if (pc !== 16'h0006 || retired !== 16'd3) begin failures++; $display("FAIL pc_after3 got pc=%h ret=%0d exp 0006/3", pc, retired); end
      end
    end
    checks++; if (state !== 3'd5 || halted !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL halt_op got st=%0d h=%b e=%b exp 5/1/0", state, halted, err); end
    checks++; if (pc !== 16'h0006 || retired !== 16'd3) begin failures++; $display("FAIL halt_op_pc got pc=%h ret=%0d exp 0006/3", pc, retired); end
    run = 1'b0; tick(); run = 1'b1; tick(); tick(); run = 1'b0; tick();
    checks++; if (state !== 3'd5 || pc !== 16'h0006 || ir !== 16'hFFFF || retired !== 16'd3) begin failures++; $display("FAIL halt_frozen got st=%0d pc=%h ir=%h ret=%0d exp 5/0006/FFFF/3", state, pc, ir, retired); end
  endtask

  task automatic test_wait_ack();
    logic exp_we;
    do_reset();
    mem[0] = 16'h20CF; mem[1] = 16'h21CF; mem[2] = 16'h00A1;
    del_tab[1] = 3;
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_we = (c == 4 || c == 11);
      checks++; if (reg_we !== exp_we) begin failures++; $display("FAIL wait_we_cycle%0d got=%b exp=%b", c, reg_we, exp_we); end
      if (c >= 5 && c <= 8) begin
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0002) begin failures++; $display("FAIL wait_addr_cycle%0d got req=%b addr=%h exp 1/0002", c, mem_if.mem_req, mem_if.mem_addr); end
      end
      if (c == 9) begin
        checks++; if (state !== 3'd2 || ir !== 16'h21CF) begin failures++; $display("FAIL wait_decode got st=%0d ir=%h exp 2/21CF", state, ir); end
      end
    end
    checks++; if (pc !== 16'h0004 || state !== 3'd1) begin failures++; $display("FAIL wait_pc got pc=%h st=%0d exp 0004/1", pc, state); end
    run = 1'b0;
  endtask

  task automatic test_timeout();
    logic saw_we;
    do_reset();
    del_tab[0] = 1000;
    saw_we = 1'b0;
    run = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (reg_we) saw_we = 1'b1;
      if (c == 15) begin
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL timeout_last_fetch got st=%0d exp=1", state); end
      end
    end
    checks++; if (state !== 3'd5 || halted !== 1'b1) begin failures++; $display("FAIL timeout_halt got st=%0d h=%b exp 5/1", state, halted); end
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin failures++; $display("FAIL timeout_err got e=%b ec=%0d exp 1/1", err, err_code); end
    checks++; if (saw_we !== 1'b0) begin failures++; $display("FAIL timeout_we got=%b exp=0", saw_we); end
    // Ack arriving in the final allowed cycle still completes the fetch.
    do_reset();
    mem[0] = 16'h20CF;
    del_tab[0] = 14;
    run = 1'b1;
    for (int c = 1; c <= 16; c++) tick();
    checks++; if (state !== 3'd2 || err !== 1'b0 || ir !== 16'h20CF) begin failures++; $display("FAIL ack_on_timeout got st=%0d e=%b ir=%h exp 2/0/20CF", state, err, ir); end
    run = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    mem[0] = 16'h5000;
    run = 1'b1;
    tick(); tick(); tick();
    checks++; if (state !== 3'd5 || err !== 1'b1 || err_code !== 2'd2) begin failures++; $display("FAIL illegal_halt got st=%0d e=%b ec=%0d exp 5/1/2", state, err, err_code); end
    checks++; if (pc !== 16'h0000 || retired !== 16'd0) begin failures++; $display("FAIL illegal_pc got pc=%h ret=%0d exp 0000/0", pc, retired); end
    rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || halted !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 || ir !== 16'h0000) begin failures++; $display("FAIL illegal_rst got st=%0d h=%b e=%b ec=%0d ir=%h exp all 0", state, halted, err, err_code, ir); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_run_drop();
    do_reset();
    mem[0] = 16'h20CF; mem[1] = 16'h21CF;
    run = 1'b1;
    tick(); tick(); tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL drop_exec got st=%0d exp=3", state); end
    run = 1'b0;
    tick();
    checks++; if (state !== 3'd4 || reg_we !== 1'b1) begin failures++; $display("FAIL drop_wb got st=%0d we=%b exp 4/1", state, reg_we); end
    tick();
    checks++; if (state !== 3'd0 || pc !== 16'h0002 || retired !== 16'd1 || reg_we !== 1'b0) begin failures++; $display("FAIL drop_idle got st=%0d pc=%h ret=%0d we=%b exp 0/0002/1/0", state, pc, retired, reg_we); end
    tick(); tick();
    checks++; if (state !== 3'd0 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL drop_stay got st=%0d req=%b exp 0/0", state, mem_if.mem_req); end
  endtask

  task automatic test_rst_mid_wb();
    do_reset();
    mem[0] = 16'h20CF;
    run = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if (reg_we !== 1'b1) begin failures++; $display("FAIL midwb_we got=%b exp=1", reg_we); end
    rst = 1'b1;
    #1;
    checks++; if (reg_we !== 1'b0 || pc !== 16'h0000 || retired !== 16'd0) begin failures++; $display("FAIL midwb_rst got we=%b pc=%h ret=%0d exp 0/0000/0", reg_we, pc, retired); end
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    run2 = 1'b1;
    tick();
    checks++; if (mem_if2.mem_req !== 1'b1 || mem_if2.mem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_addr got req=%b addr=%h exp 1/FFFE", mem_if2.mem_req, mem_if2.mem_addr); end
    tick(); tick();
    run2 = 1'b0;
    tick(); tick();
    checks++; if (pc2 !== 16'h0000 || retired2 !== 16'd1 || state2 !== 3'd0) begin failures++; $display("FAIL wrap_pc got pc=%h ret=%0d st=%0d exp 0000/1/0", pc2, retired2, state2); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    fcnt = 0;
    test_reset();
    test_three_instr();
    test_wait_ack();
    test_timeout();
    test_illegal();
    test_run_drop();
    test_rst_mid_wb();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
